// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS subset core: PC, unified word memory, register file, ALU, decode.
// Optional bne decode (op 0x05) is enabled by defining MIPS_BNE_EN.
module mips_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   idata,
  input  logic [AW-1:0] daddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  assign idata = mem[iaddr];
  assign rdata = mem[daddr];

  always_ff @(posedge clk) begin
    if (we) mem[daddr] <= wdata;
  end
endmodule

module mips_reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [0:31];

  // $0 is hardwired: reads forced to zero, writes dropped
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) mem[wa] <= wd;
  end
endmodule

module mips_single_cycle #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [15:0] imm;
  logic [25:0] target;
  logic signed [31:0] sext, alu_a, alu_b, alu_y;
  logic [31:0] rd1, rd2, dmem_rd, wb;
  logic        reg_write, reg_dst, alu_src, mem_to_reg, mem_write;
  logic        branch_eq, branch_ne, jump, zero, taken;
  alu_op_t     alu_op;

  function automatic logic signed [31:0] alu(input alu_op_t f,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    case (f)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (a < b) ? 32'sd1 : 32'sd0;
      default: return a + b;
    endcase
  endfunction

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];
  assign sext   = {{16{imm[15]}}, imm};

  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    case (op)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22:        alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h2A:        alu_op = ALU_SLT;
          default:      reg_write = 1'b0;
        endcase
      end
      6'h08: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'h23: begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
      6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'h04: begin branch_eq = 1'b1; alu_op = ALU_SUB; end
      6'h02: jump = 1'b1;
`ifdef MIPS_BNE_EN
      6'h05: begin branch_ne = 1'b1; alu_op = ALU_SUB; end
`endif
      default: ;
    endcase
  end

  assign alu_a = rd1;
  assign alu_b = alu_src ? sext : rd2;
  assign alu_y = alu(alu_op, alu_a, alu_b);
  assign zero  = (alu_y == 32'sd0);
  assign taken = (branch_eq & zero) | (branch_ne & ~zero);

  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = jump  ? {pc_plus4[31:28], target, 2'b00} :
                    taken ? pc_plus4 + {sext[29:0], 2'b00} : pc_plus4;

  assign wa = reg_dst ? rd : rt;
  assign wb = mem_to_reg ? dmem_rd : alu_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // State writes are blocked while reset is held so preloaded contents survive
  mips_mem #(.WORDS(MEM_WORDS), .AW(AW)) mem1 (
    .clk   (clk),
    .we    (mem_write & ~rst),
    .iaddr (pc[AW+1:2]),
    .idata (instr),
    .daddr (alu_y[AW+1:2]),
    .wdata (rd2),
    .rdata (dmem_rd)
  );

  mips_reg_file reg_file1 (
    .clk (clk),
    .we  (reg_write & ~rst),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wa),
    .wd  (wb),
    .rd1 (rd1),
    .rd2 (rd2)
  );
endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: directed cases plus random programs against an ISA-level model.
module tb_mips_single_cycle;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_single_cycle #(.MEM_WORDS(MW), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  int tests = 0;
  int fails = 0;
  logic [31:0] m_mem [0:MW-1];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  // One instruction of architectural semantics
  task automatic model_step;
    logic [31:0] ins, a, b, se, pc4, res;
    logic [5:0] op, fn;
    int dst;
    ins = m_mem[widx(m_pc)];
    op = ins[31:26]; fn = ins[5:0];
    a = m_reg[ins[25:21]]; b = m_reg[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]};
    pc4 = m_pc + 4;
    m_pc = pc4;
    dst = -1; res = 0;
    case (op)
      6'h00: begin
        dst = ins[15:11];
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: dst = -1;
        endcase
      end
      6'h08: begin dst = ins[20:16]; res = a + se; end
      6'h23: begin dst = ins[20:16]; res = m_mem[widx(a + se)]; end
      6'h2B: m_mem[widx(a + se)] = b;
      6'h04: if (a == b) m_pc = pc4 + (se << 2);
`ifdef MIPS_BNE_EN
      6'h05: if (a != b) m_pc = pc4 + (se << 2);
`endif
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (dst > 0) m_reg[dst] = res;
  endtask

  task automatic compare_state;
    int rbad, mbad;
    rbad = 0; mbad = 0;
    check("pc", dut.pc, m_pc);
    for (int i = 31; i >= 0; i--) if (dut.reg_file1.mem[i] !== m_reg[i]) rbad = i;
    check($sformatf("reg%0d", rbad), dut.reg_file1.mem[rbad], m_reg[rbad]);
    for (int i = MW - 1; i >= 0; i--) if (dut.mem1.mem[i] !== m_mem[i]) mbad = i;
    check($sformatf("mem%0d", mbad), dut.mem1.mem[mbad], m_mem[mbad]);
  endtask

  task automatic clear_all;
    rst = 1'b1;
    m_pc = 32'h0;
    for (int i = 0; i < MW; i++) begin m_mem[i] = 0; dut.mem1.mem[i] = 0; end
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; dut.reg_file1.mem[i] = 0; end
  endtask

  task automatic put_mem(input int i, input logic [31:0] v);
    m_mem[i] = v; dut.mem1.mem[i] = v;
  endtask

  task automatic put_reg(input int i, input logic [31:0] v);
    m_reg[i] = v; dut.reg_file1.mem[i] = v;
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0;
    #1 compare_state;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_step;
      compare_state;
    end
  endtask

  function automatic logic [31:0] gen_instr;
    logic [4:0] rs, rt, rd;
    logic [5:0] fns [6] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [15:0] off;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    off = 16'($signed($urandom_range(0, 8)) - 4);
    case ($urandom_range(0, 9))
      0, 1: return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
      2:    return {6'h08, rs, rt, 16'($urandom)};
      3:    return {6'h23, 5'd0, rt, 16'($urandom_range(64, 255) * 4)};
      4:    return {6'h23, rs, rt, 16'($urandom)};
      5:    return {6'h2B, 5'd0, rt, 16'($urandom_range(64, 255) * 4)};
      6:    return {6'h04, rs, rt, off};
      7:    return {6'h05, rs, rt, off};
      8:    return {6'h02, 26'($urandom_range(0, 63))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]  fn_t [3] = '{6'h20, 6'h22, 6'h2A};
    logic [31:0] ex_t [3] = '{32'd12, 32'hFFFF_FFFE, 32'd1};

    // Reset: preloads survive, no writes while held
    clear_all;
    put_reg(9, 32'h1234_5678);
    put_mem(0, 32'h2005_0007);
    put_mem(20, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", dut.pc, 32'h0);
    check("rst_no_reg_write", dut.reg_file1.mem[5], 32'h0);
    check("rst_reg9_kept", dut.reg_file1.mem[9], 32'h1234_5678);
    check("rst_mem20_kept", dut.mem1.mem[20], 32'hCAFE_F00D);
    release_rst;
    step(1);
    check("addi_r5", dut.reg_file1.mem[5], 32'd7);

    // ALU R-type
    for (int k = 0; k < 3; k++) begin
      clear_all;
      put_reg(1, 5); put_reg(2, 7);
      put_mem(0, 32'h0022_1800 | 32'(fn_t[k]));
      release_rst;
      step(1);
      check($sformatf("alu_fn%0h", fn_t[k]), dut.reg_file1.mem[3], ex_t[k]);
      check($sformatf("model_fn%0h", fn_t[k]), m_reg[3], ex_t[k]);
    end

    // Load then store, lw result used by the next instruction
    clear_all;
    put_mem(16, 32'hDEAD_BEEF);
    put_mem(0, 32'h8C01_0040);
    put_mem(1, 32'hAC01_0044);
    release_rst;
    step(2);
    check("lw_r1", dut.reg_file1.mem[1], 32'hDEAD_BEEF);
    check("sw_mem17", dut.mem1.mem[17], 32'hDEAD_BEEF);

    // beq taken / not taken
    for (int k = 0; k < 2; k++) begin
      clear_all;
      put_reg(1, 3); put_reg(2, (k == 0) ? 3 : 4);
      put_mem(0, 32'h1022_0002);
      release_rst;
      step(1);
      check(k == 0 ? "beq_taken" : "beq_not_taken", dut.pc, (k == 0) ? 32'h0C : 32'h04);
    end

    // Jump, $0 writes, negative immediate, async reset
    clear_all;
    put_mem(0, 32'h0800_0004);
    put_mem(4, 32'h2000_0005);
    put_mem(5, 32'h2004_FFFF);
    release_rst;
    step(1);
    check("j_pc", dut.pc, 32'h10);
    step(2);
    check("r0_zero", dut.reg_file1.mem[0], 32'h0);
    check("addi_neg", dut.reg_file1.mem[4], 32'hFFFF_FFFF);
    check("model_addi_neg", m_reg[4], 32'hFFFF_FFFF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_pc", dut.pc, 32'h0);
    m_pc = 32'h0;
    release_rst;

    // bne (optional feature)
    clear_all;
    put_reg(1, 1); put_reg(2, 2);
    put_mem(0, 32'h1422_0001);
    release_rst;
    step(1);
`ifdef MIPS_BNE_EN
    check("bne_pc", dut.pc, 32'h08);
`else
    check("bne_nop_pc", dut.pc, 32'h04);
`endif

    // Random programs
    for (int p = 0; p < 8; p++) begin
      clear_all;
      for (int i = 1; i < 32; i++) put_reg(i, (i < 4) ? 32'($urandom_range(0, 1023)) : $urandom);
      for (int i = 0; i < 64; i++) put_mem(i, gen_instr());
      for (int i = 64; i < MW; i++) put_mem(i, $urandom);
      release_rst;
      step(150);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
